unified_buffer_reader: RTL and testbench

Read sequencer directly upstream of the unified buffer's port 0 and downstream consumer path. It accepts a (base address, length) command, issues consecutive `addr0`/`en0` reads, and tracks the fixed unified-buffer read latency. It returns the rows as a valid/ready stream with a `last` flag. A credit-limited skid FIFO absorbs in-flight rows so that consumer backpressure never drops data.

---
 rtl/tpu_pkg.sv | 14 +
 rtl/unified_buffer_reader_pkg.sv | 20 ++
 rtl/unified_buffer_reader_if.sv | 28 ++
 rtl/unified_buffer_reader_sync_fifo.sv | 54 +++++
 rtl/unified_buffer_reader.sv | 141 ++++++++++++++
 tb/tb_unified_buffer_reader.sv | 322 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types and constants.
// byte_type / buffer_addr_type describe one unified-buffer byte and row address.
// UB_READ_LATENCY is the cycle count from an addr0/en0 read to valid read_port0
// data: one RAM register plus two output registers. Both the unified buffer and
// its read sequencer use it.
package tpu_pkg;
   localparam int BYTE_WIDTH           = 8;
   localparam int BUFFER_ADDRESS_WIDTH = 24;

   typedef logic [BYTE_WIDTH-1:0]           byte_type;
   typedef logic [BUFFER_ADDRESS_WIDTH-1:0] buffer_addr_type;

   localparam int UB_READ_LATENCY = 3;
endpackage

// File: rtl/unified_buffer_reader_pkg.sv
// Local types for the unified buffer read sequencer.
// reader_state_t : sequencer FSM states.
// popcount32     : number of set bits. It counts the reads still travelling
//                  down the buffer's read pipeline.
package unified_buffer_reader_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } reader_state_t;

   function automatic int popcount32(input logic [31:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction
endpackage

// File: rtl/unified_buffer_reader_if.sv
// Row stream from the unified buffer reader to its consumer.
//   out_data  : one buffer row (MATRIX_WIDTH bytes, byte 0 in the low bits)
//   out_valid : out_data holds a row
//   out_ready : the consumer takes the row on this clock edge
//   out_last  : the row is the final one of the current command
// Modport master is the reader side. Modport slave is the consumer side.
interface unified_buffer_reader_if #(
   parameter int MATRIX_WIDTH = 14
) ();
   tpu_pkg::byte_type [MATRIX_WIDTH-1:0] out_data;
   logic                                 out_valid;
   logic                                 out_ready;
   logic                                 out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/unified_buffer_reader_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst   : clock and asynchronous active-high reset (clears pointers/count)
//   push       : write push_data this cycle. Pushes into a full FIFO are ignored.
//   pop        : drop the head entry this cycle. Pops of an empty FIFO are ignored.
//   head_data  : current head entry. It is valid whenever count != 0.
//   count      : number of stored entries
// The storage array has no reset. Only the pointers decide what is valid.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push, do_pop;

   assign do_push = push && (count_reg != CNT_W'(DEPTH));
   assign do_pop  = pop && (count_reg != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   assign head_data = mem[rd_ptr_reg];
   assign count     = count_reg;
endmodule

// File: rtl/unified_buffer_reader.sv
// unified_buffer_reader: reads `length` consecutive rows from unified-buffer
// port 0, starting at base_addr. It returns them as a valid/ready stream with a
// last flag.
//   clk, rst          : clock, asynchronous active-high reset
//   start/base_addr/length : command. It is sampled only while idle. length 0 only pulses done.
//   busy, done        : command in progress / one-cycle completion pulse
//   ub_addr0, ub_en0  : read request to the unified buffer
//   ub_read_port0     : read data. It arrives UB_READ_LATENCY cycles after the request.
//   ub_enable, ub_master_en : unified-buffer enables for the time this block owns port 0
//   out_if            : row stream to the consumer
// A read is issued only when its row is sure to have a FIFO slot when it lands.
// The test is (reads in flight + rows stored) < FIFO_DEPTH. Because of this,
// consumer backpressure never drops a row.
module unified_buffer_reader
   import tpu_pkg::*;
   import unified_buffer_reader_pkg::*;
#(
   parameter int MATRIX_WIDTH = 14,
   parameter int FIFO_DEPTH   = 8,
   parameter int LENGTH_WIDTH = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  buffer_addr_type              base_addr,
   input  logic [LENGTH_WIDTH-1:0]      length,
   output logic                         busy,
   output logic                         done,
   output buffer_addr_type              ub_addr0,
   output logic                         ub_en0,
   input  byte_type [MATRIX_WIDTH-1:0]  ub_read_port0,
   output logic                         ub_enable,
   output logic                         ub_master_en,
   unified_buffer_reader_if.master      out_if
);
   localparam int ROW_WIDTH = MATRIX_WIDTH * BYTE_WIDTH;
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [LENGTH_WIDTH-1:0] LEN_ONE = LENGTH_WIDTH'(1);

   reader_state_t               state_reg, state_next;
   buffer_addr_type             base_reg, last_addr_reg, issue_addr;
   logic [LENGTH_WIDTH-1:0]     length_reg, issue_cnt_reg, rx_cnt_reg, last_idx;
   logic [UB_READ_LATENCY-1:0]  sr_reg;       // issue strobes moving through the buffer read pipeline
   logic                        done_reg, done_next;
   logic                        accept, issue, credit_ok, pop, out_valid_int;
   int                          inflight;
   logic [CNT_W-1:0]            fifo_count;
   logic [ROW_WIDTH-1:0]        fifo_head;

   assign last_idx   = length_reg - LEN_ONE;
   assign issue_addr = base_reg + buffer_addr_type'(issue_cnt_reg);   // wraps modulo 2^AW
   assign inflight   = popcount32(32'(sr_reg));
   assign credit_ok  = (inflight + int'(fifo_count)) < FIFO_DEPTH;
   assign accept     = (state_reg == ST_IDLE) && start && (length != '0);

   // Next-state and issue logic
   always_comb begin
      state_next = state_reg;
      issue      = 1'b0;
      done_next  = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (start) begin
               if (length != '0) state_next = ST_ISSUE;
               else              done_next  = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (issue_cnt_reg == last_idx) state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (pop && (rx_cnt_reg == last_idx)) begin
               state_next = ST_IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         base_reg      <= '0;
         length_reg    <= '0;
         issue_cnt_reg <= '0;
         rx_cnt_reg    <= '0;
         last_addr_reg <= '0;
         sr_reg        <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg <= state_next;
         done_reg  <= done_next;
         sr_reg    <= {sr_reg[UB_READ_LATENCY-2:0], issue};
         if (accept) begin
            base_reg      <= base_addr;
            length_reg    <= length;
            issue_cnt_reg <= '0;
            rx_cnt_reg    <= '0;
         end else begin
            if (issue) begin
               issue_cnt_reg <= issue_cnt_reg + LEN_ONE;
               last_addr_reg <= issue_addr;
            end
            if (pop) rx_cnt_reg <= rx_cnt_reg + LEN_ONE;
         end
      end
   end

   // The row read UB_READ_LATENCY cycles ago is on ub_read_port0 while the tail strobe is set.
   sync_fifo #(
      .WIDTH (ROW_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (sr_reg[UB_READ_LATENCY-1]),
      .push_data (ub_read_port0),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   assign out_valid_int    = (fifo_count != '0);
   assign pop              = out_valid_int && out_if.out_ready;
   assign out_if.out_valid = out_valid_int;
   // Gate the unreset storage so out_data reads zero whenever no row is presented.
   assign out_if.out_data  = out_valid_int ? fifo_head : '0;
   assign out_if.out_last  = out_valid_int && (rx_cnt_reg == last_idx);

   assign busy         = (state_reg != ST_IDLE);
   assign done         = done_reg;
   assign ub_en0       = issue;
   // Keep showing the last issued address when no read is issued.
   assign ub_addr0     = issue ? issue_addr : last_addr_reg;
   assign ub_enable    = busy;
   assign ub_master_en = 1'b0;
endmodule

// File: tb/tb_unified_buffer_reader.sv
// Scoreboard bench for unified_buffer_reader. The stimulus pushes expected rows.
// A negedge monitor pops them and compares them with every handshake.
module tb_unified_buffer_reader;
   import tpu_pkg::*;

   localparam int MW = 14;
   localparam int LW = 16;
   localparam int AW = BUFFER_ADDRESS_WIDTH;
   localparam logic [7:0] BYTE0 [14] = '{8'h7F, 8'h85, 8'h8B, 8'h91, 8'h97, 8'h9D, 8'hA3,
                                         8'hA9, 8'hAF, 8'hB5, 8'hBB, 8'hC1, 8'hC5, 8'hC9};

   typedef struct packed {
      logic [MW*8-1:0] data;
      logic            last;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   buffer_addr_type base_addr = '0;
   logic [LW-1:0]   length = '0;
   logic            busy, done, ub_en0, ub_enable, ub_master_en;
   buffer_addr_type ub_addr0;
   byte_type [MW-1:0] ub_read_port0;

   unified_buffer_reader_if #(.MATRIX_WIDTH(MW)) out_if ();

   unified_buffer_reader #(
      .MATRIX_WIDTH (MW),
      .FIFO_DEPTH   (8),
      .LENGTH_WIDTH (LW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .length        (length),
      .busy          (busy),
      .done          (done),
      .ub_addr0      (ub_addr0),
      .ub_en0        (ub_en0),
      .ub_read_port0 (ub_read_port0),
      .ub_enable     (ub_enable),
      .ub_master_en  (ub_master_en),
      .out_if        (out_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Unified-buffer model: byte j of a row is byte0 - j.
   function automatic logic [MW*8-1:0] row_word(input buffer_addr_type a);
      logic [7:0]      b0;
      logic [MW*8-1:0] w;
      if (a < 14) b0 = BYTE0[a[3:0]];
      else        b0 = a[7:0] ^ 8'h5A;
      for (int j = 0; j < MW; j++) w[j*8 +: 8] = b0 - 8'(j);
      return w;
   endfunction

   logic [MW*8-1:0] ram_q = '0, pipe1 = '0, pipe2 = '0;
   always @(posedge clk) begin
      if (ub_en0) ram_q <= row_word(ub_addr0);
      pipe1 <= ram_q;
      pipe2 <= pipe1;
   end
   assign ub_read_port0 = pipe2;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Logs and scoreboard
   buffer_addr_type en_log[$];
   int              en_cyc[$];
   int              beat_cyc[$];
   logic [MW*8-1:0] beat_data[$];
   beat_t           exp_q[$];
   int              done_count = 0;
   logic            hold_pending = 1'b0;
   logic [MW*8-1:0] hold_data = '0;

   always @(negedge clk) begin
      beat_t e;
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (ub_en0) begin
            en_log.push_back(ub_addr0);
            en_cyc.push_back(cyc);
         end
         if (done) done_count++;
         if (hold_pending) begin
            check("valid_held", out_if.out_valid, 1);
            if (out_if.out_valid) check("data_held", out_if.out_data, hold_data);
         end
         if (out_if.out_valid && out_if.out_ready) begin
            beat_cyc.push_back(cyc);
            beat_data.push_back(out_if.out_data);
            $display("beat cyc=%0d data=%h last=%0b", cyc, out_if.out_data, out_if.out_last);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %h required no beat", out_if.out_data);
            end else begin
               e = exp_q.pop_front();
               check("beat_data", out_if.out_data, e.data);
               check("beat_last", out_if.out_last, e.last);
            end
         end
         hold_pending = out_if.out_valid && !out_if.out_ready;
         hold_data    = out_if.out_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      en_log.delete();
      en_cyc.delete();
      beat_cyc.delete();
      beat_data.delete();
      done_count = 0;
   endtask

   task automatic expect_rows(input buffer_addr_type b, input int n);
      beat_t e;
      for (int i = 0; i < n; i++) begin
         e.data = row_word(b + buffer_addr_type'(i));
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   // Called just after a clock edge. Returns the cycle in which start was presented.
   task automatic issue_cmd(output int s, input buffer_addr_type b, input int n);
      start     = 1'b1;
      base_addr = b;
      length    = LW'(n);
      s         = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if (done) begin
            at = cyc;
            break;
         end
         tick();
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL %s: done not seen within %0d cycles, required a pulse", name, budget);
      end
   endtask

   function automatic int qi(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d;
      buffer_addr_type wrap_exp [4];
      out_if.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_en0", ub_en0, 0);
      check("rst_addr0", ub_addr0, 0);
      check("rst_valid", out_if.out_valid, 0);
      check("rst_last", out_if.out_last, 0);
      check("rst_data", out_if.out_data, 0);
      rst = 1'b0;
      tick();

      // T1: base 0, 14 rows, consumer always ready
      clear_logs();
      expect_rows('0, 14);
      issue_cmd(s, '0, 14);
      check("t1_busy", busy, 1);
      check("t1_ub_enable", ub_enable, 1);
      wait_done(200, "t1_done", d);
      tick();
      check("t1_done_pulse", done, 0);
      check("t1_done_count", done_count, 1);
      check("t1_en_count", en_log.size(), 14);
      for (int i = 0; i < 14; i++)
         check($sformatf("t1_addr%0d", i), (i < en_log.size()) ? en_log[i] : 'x, i);
      check("t1_first_en", qi(en_cyc, 0), s + 1);
      check("t1_beat_count", beat_cyc.size(), 14);
      check("t1_first_beat", qi(beat_cyc, 0), qi(en_cyc, 0) + 4);
      check("t1_last_beat", qi(beat_cyc, 13), s + 1 + 4 + 13);
      check("t1_done_cycle", d, s + 1 + 4 + 13 + 1);
      check("t1_beat0", (beat_data.size() > 0) ? beat_data[0] : 'x,
            112'h72737475767778797A7B7C7D7E7F);
      check("t1_beat13", (beat_data.size() > 13) ? beat_data[13] : 'x,
            112'hBCBDBEBFC0C1C2C3C4C5C6C7C8C9);
      check("t1_scoreboard_empty", exp_q.size(), 0);

      // T2: address wrap at the top of the buffer
      clear_logs();
      wrap_exp[0] = {AW{1'b1}} - buffer_addr_type'(1);
      wrap_exp[1] = {AW{1'b1}};
      wrap_exp[2] = '0;
      wrap_exp[3] = buffer_addr_type'(1);
      expect_rows(wrap_exp[0], 4);
      issue_cmd(s, wrap_exp[0], 4);
      wait_done(100, "t2_done", d);
      check("t2_en_count", en_log.size(), 4);
      for (int i = 0; i < 4; i++)
         check($sformatf("t2_addr%0d", i), (i < en_log.size()) ? en_log[i] : 'x, wrap_exp[i]);
      check("t2_scoreboard_empty", exp_q.size(), 0);

      // T3: start presented in the done cycle, then a 12-cycle stall after 2 beats
      clear_logs();
      expect_rows('0, 14);
      issue_cmd(s, '0, 14);
      for (int i = 0; i < 50; i++) begin
         if (beat_cyc.size() >= 2) break;
         tick();
      end
      out_if.out_ready = 1'b0;
      repeat (12) tick();
      check("t3_first_en", qi(en_cyc, 0), s + 1);
      check("t3_stall_beats", beat_cyc.size(), 2);
      check("t3_stall_issued", en_log.size(), 10);
      check("t3_stall_en0", ub_en0, 0);
      out_if.out_ready = 1'b1;
      wait_done(200, "t3_done", d);
      tick();
      check("t3_en_count", en_log.size(), 14);
      check("t3_beat_count", beat_cyc.size(), 14);
      check("t3_scoreboard_empty", exp_q.size(), 0);

      // T4: zero-length command
      repeat (3) tick();
      clear_logs();
      issue_cmd(s, buffer_addr_type'(7), 0);
      wait_done(5, "t4_done", d);
      check("t4_done_cycle", d, s + 1);
      repeat (8) tick();
      check("t4_no_en", en_log.size(), 0);
      check("t4_no_beats", beat_cyc.size(), 0);
      check("t4_done_count", done_count, 1);
      check("t4_busy", busy, 0);

      // T5: reset two cycles after the first issue of a 10-row command
      clear_logs();
      issue_cmd(s, '0, 10);
      for (int i = 0; i < 10; i++) begin
         if (en_log.size() >= 1) break;
         tick();
      end
      tick();
      rst = 1'b1;
      #1;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_en0", ub_en0, 0);
      check("t5_addr0", ub_addr0, 0);
      check("t5_valid", out_if.out_valid, 0);
      check("t5_last", out_if.out_last, 0);
      check("t5_data", out_if.out_data, 0);
      exp_q.delete();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      clear_logs();
      expect_rows(buffer_addr_type'(5), 2);
      issue_cmd(s, buffer_addr_type'(5), 2);
      wait_done(50, "t5_done_after", d);
      repeat (4) tick();
      check("t5_beat_count", beat_cyc.size(), 2);
      check("t5_en_count", en_log.size(), 2);
      check("t5_scoreboard_empty", exp_q.size(), 0);

      // T6: second start during ISSUE is ignored
      clear_logs();
      expect_rows('0, 6);
      issue_cmd(s, '0, 6);
      tick();
      start     = 1'b1;
      base_addr = buffer_addr_type'(9);
      length    = LW'(3);
      tick();
      start = 1'b0;
      wait_done(100, "t6_done", d);
      repeat (10) tick();
      check("t6_en_count", en_log.size(), 6);
      check("t6_last_addr", (en_log.size() > 0) ? en_log[en_log.size()-1] : 'x, 5);
      check("t6_done_count", done_count, 1);
      check("t6_beat_count", beat_cyc.size(), 6);
      check("t6_scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
